// File: rtl/cdr_trigger_arm_controller.sv
// cdr_trigger_arm_controller: selects the CDR trigger source by mode, qualifies it on symbol lock,
// and sequences arm / single-shot / auto-rearm with holdoff while counting triggers.
module cdr_trigger_arm_controller #(
    parameter int LOCK_QUAL_CYCLES = 256,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                     rx_clk,
    input  logic                     rst,
    input  logic [7:0]               cfg_mode,
    input  logic                     cfg_arm,
    input  logic                     cfg_disarm,
    input  logic                     cfg_single,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic                     cfg_count_clear,
    input  logic                     lock_8b10b,
    input  logic                     lock_64b66b,
    input  logic                     hit_8b10b_match,
    input  logic                     hit_8b10b_disperr,
    input  logic                     hit_64b66b_match,
    input  logic                     hit_64b66b_invalid,
    output logic                     trig_out,
    output logic [2:0]               state,
    output logic                     armed,
    output logic                     lock_lost,
    output logic                     mode_err,
    output logic [COUNT_WIDTH-1:0]   trig_count
);
    localparam int QW = $clog2(LOCK_QUAL_CYCLES + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, QUALIFY = 3'd1, ARMED = 3'd2, HOLDOFF = 3'd3, DONE = 3'd4} state_t;
    state_t state_q, state_nxt;
    logic [1:0] sel_q;
    logic single_q;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, hold_cnt;
    logic [QW-1:0] qual_cnt;
    logic mode_ok, arm_ok, arm_bad, sel_lock, sel_hit, qual_done, fire, lost;
    assign mode_ok = cfg_mode inside {8'h00, 8'h01, 8'h80, 8'h81};
    assign arm_ok = cfg_arm && !cfg_disarm && mode_ok;
    assign arm_bad = cfg_arm && !cfg_disarm && !mode_ok;
    // Only mode bits 7 (line code) and 0 (event kind) distinguish the four valid modes
    assign sel_lock = sel_q[1] ? lock_64b66b : lock_8b10b;
    assign sel_hit = sel_q[1] ? (sel_q[0] ? hit_64b66b_invalid : hit_64b66b_match)
                              : (sel_q[0] ? hit_8b10b_disperr : hit_8b10b_match);
    assign qual_done = qual_cnt == QW'(LOCK_QUAL_CYCLES - 1);
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end
    always_comb begin
        state_nxt = state_q;
        fire = 1'b0;
        lost = 1'b0;
        if (cfg_disarm)
            state_nxt = IDLE;
        else if (cfg_arm)
            state_nxt = mode_ok ? QUALIFY : state_q;
        else
            case (state_q)
                QUALIFY: state_nxt = (sel_lock && qual_done) ? ARMED : QUALIFY;
                ARMED, HOLDOFF: begin
                    lost = !sel_lock;
                    fire = sel_lock && sel_hit && state_q == ARMED;
                    if (lost)
                        state_nxt = QUALIFY;
                    else if (fire)
                        state_nxt = single_q ? DONE : (holdoff_q == '0 ? ARMED : HOLDOFF);
                    else if (state_q == HOLDOFF && hold_cnt == HOLDOFF_WIDTH'(1))
                        state_nxt = ARMED;
                end
                default: ;
            endcase
    end
    always_comb begin
        state = state_q;
        armed = state_q == ARMED;
    end
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            single_q <= 1'b0;
            holdoff_q <= '0;
            qual_cnt <= '0;
            hold_cnt <= '0;
            trig_out <= 1'b0;
            trig_count <= '0;
            lock_lost <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            if (arm_ok) begin
                sel_q <= {cfg_mode[7], cfg_mode[0]};
                single_q <= cfg_single;
                holdoff_q <= cfg_holdoff;
            end
            qual_cnt <= arm_bad ? qual_cnt
                      : (!cfg_disarm && !cfg_arm && state_q == QUALIFY && sel_lock && !qual_done) ? qual_cnt + 1'b1 : '0;
            hold_cnt <= fire ? holdoff_q : (state_q == HOLDOFF ? hold_cnt - 1'b1 : hold_cnt);
            trig_out <= fire;
            trig_count <= cfg_count_clear ? COUNT_WIDTH'(fire)
                        : (fire && !(&trig_count)) ? trig_count + 1'b1 : trig_count;
            lock_lost <= arm_ok ? 1'b0 : (lock_lost | lost);
            mode_err <= arm_ok ? 1'b0 : (mode_err | arm_bad);
        end
    end
endmodule

// File: tb/tb_cdr_trigger_arm_controller.sv
// tb_cdr_trigger_arm_controller: directed stimulus checked every cycle against a behavioural model,
// plus literal expectations at the key points of each scenario.
module tb_cdr_trigger_arm_controller;
    localparam int LQ = 4;
    localparam int HW = 8;
    localparam int CW = 2;
    logic rx_clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] cfg_mode = '0;
    logic cfg_arm = 1'b0, cfg_disarm = 1'b0, cfg_single = 1'b0, cfg_count_clear = 1'b0;
    logic [HW-1:0] cfg_holdoff = '0;
    logic lock_8b10b = 1'b0, lock_64b66b = 1'b0;
    logic hit_8b10b_match = 1'b0, hit_8b10b_disperr = 1'b0, hit_64b66b_match = 1'b0, hit_64b66b_invalid = 1'b0;
    logic trig_out, armed, lock_lost, mode_err;
    logic [2:0] state;
    logic [CW-1:0] trig_count;
    int errors = 0;
    int checks = 0;
    int m_st, m_cnt, run, hl, m_hold, pulses;
    logic [7:0] m_mode;
    bit m_single, m_trig, m_ll, m_me, lk, hit, fire;

    cdr_trigger_arm_controller #(.LOCK_QUAL_CYCLES(LQ), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) dut (
        .rx_clk(rx_clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_arm(cfg_arm), .cfg_disarm(cfg_disarm),
        .cfg_single(cfg_single), .cfg_holdoff(cfg_holdoff), .cfg_count_clear(cfg_count_clear),
        .lock_8b10b(lock_8b10b), .lock_64b66b(lock_64b66b), .hit_8b10b_match(hit_8b10b_match),
        .hit_8b10b_disperr(hit_8b10b_disperr), .hit_64b66b_match(hit_64b66b_match),
        .hit_64b66b_invalid(hit_64b66b_invalid), .trig_out(trig_out), .state(state), .armed(armed),
        .lock_lost(lock_lost), .mode_err(mode_err), .trig_count(trig_count));

    always #5 rx_clk = ~rx_clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    // Behavioural model: states as the visible 0..4 codes, qualification as a run length,
    // holdoff as cycles remaining.
    always @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_cnt = 0; run = 0; hl = 0; m_hold = 0;
            m_mode = 8'h00; m_single = 0; m_trig = 0; m_ll = 0; m_me = 0;
        end else begin
            fire = 0;
            lk = m_mode[7] ? lock_64b66b : lock_8b10b;
            case (m_mode)
                8'h00: hit = hit_8b10b_match;
                8'h01: hit = hit_8b10b_disperr;
                8'h80: hit = hit_64b66b_match;
                default: hit = hit_64b66b_invalid;
            endcase
            if (cfg_disarm)
                m_st = 0;
            else if (cfg_arm) begin
                if (cfg_mode == 8'h00 || cfg_mode == 8'h01 || cfg_mode == 8'h80 || cfg_mode == 8'h81) begin
                    m_st = 1; run = 0; m_ll = 0; m_me = 0;
                    m_mode = cfg_mode; m_single = cfg_single; m_hold = int'(cfg_holdoff);
                end else
                    m_me = 1;
            end else if (m_st == 1) begin
                run = lk ? run + 1 : 0;
                if (run == LQ) begin
                    m_st = 2;
                    run = 0;
                end
            end else if ((m_st == 2 || m_st == 3) && !lk) begin
                m_st = 1; m_ll = 1; run = 0;
            end else if (m_st == 2 && hit) begin
                fire = 1;
                if (m_single)
                    m_st = 4;
                else if (m_hold != 0) begin
                    m_st = 3;
                    hl = m_hold;
                end
            end else if (m_st == 3) begin
                hl = hl - 1;
                if (hl == 0)
                    m_st = 2;
            end
            m_trig = fire;
            m_cnt = cfg_count_clear ? int'(fire) : (fire && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        end
    end

    always @(negedge rx_clk) begin
        if (!rst) begin
            chk("m_state", int'(state), m_st);
            chk("m_trig_out", int'(trig_out), int'(m_trig));
            chk("m_armed", int'(armed), int'(m_st == 2));
            chk("m_lock_lost", int'(lock_lost), int'(m_ll));
            chk("m_mode_err", int'(mode_err), int'(m_me));
            chk("m_trig_count", int'(trig_count), m_cnt);
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_trig", int'(trig_out), 0);
        chk("rst_count", int'(trig_count), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_flags", int'({lock_lost, mode_err}), 0);
        lock_8b10b = 1; lock_64b66b = 1;
        {hit_8b10b_match, hit_8b10b_disperr, hit_64b66b_match, hit_64b66b_invalid} = 4'hF;
        tick(3);
        chk("idle_no_trig", int'(trig_count), 0);
        {hit_8b10b_match, hit_8b10b_disperr, hit_64b66b_match, hit_64b66b_invalid} = 4'h0;
        // qualification with steady lock
        cfg_mode = 8'h00; cfg_arm = 1; tick; cfg_arm = 0;
        tick(3); chk("qual_c4", int'(armed), 0);
        tick; chk("qual_c5", int'(armed), 1);
        cfg_disarm = 1; tick; cfg_disarm = 0;
        // qualification with a dropout in cycle 2
        cfg_arm = 1; tick; cfg_arm = 0;
        tick; lock_8b10b = 0; tick; lock_8b10b = 1;
        tick(3); chk("drop_c6", int'(armed), 0);
        tick; chk("drop_c7", int'(armed), 1);
        cfg_disarm = 1; tick; cfg_disarm = 0;
        // auto-rearm, holdoff 3
        cfg_mode = 8'h80; cfg_holdoff = 3; cfg_single = 0; lock_8b10b = 0; lock_64b66b = 1;
        cfg_count_clear = 1; tick; cfg_count_clear = 0;
        cfg_arm = 1; tick; cfg_arm = 0;
        tick(4); chk("ar_armed", int'(armed), 1);
        pulses = 0;
        hit_64b66b_match = 1;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (trig_out) pulses++;
            if (i == 1) chk("ar_hit1", int'(trig_out), 1);
            if (i == 5) chk("ar_hit5", int'(trig_out), 1);
        end
        hit_64b66b_match = 0;
        chk("ar_pulses", pulses, 2);
        chk("ar_count", int'(trig_count), 2);
        cfg_holdoff = 0; tick(4);
        // holdoff 0: back-to-back triggers, counter saturates
        cfg_arm = 1; cfg_count_clear = 1; tick; cfg_arm = 0; cfg_count_clear = 0;
        tick(4); chk("h0_armed", int'(armed), 1);
        hit_64b66b_match = 1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            chk("h0_pulse", int'(trig_out), 1);
        end
        hit_64b66b_match = 0;
        chk("sat_count", int'(trig_count), 3);
        tick;
        hit_64b66b_match = 1; cfg_count_clear = 1; tick; hit_64b66b_match = 0; cfg_count_clear = 0;
        chk("clr_trig_count", int'(trig_count), 1);
        // async reset while trig_out is high
        hit_64b66b_match = 1; tick; hit_64b66b_match = 0;
        chk("pre_rst_trig", int'(trig_out), 1);
        #2 rst = 1;
        #1 chk("async_trig", int'(trig_out), 0);
        chk("async_count", int'(trig_count), 0);
        tick; rst = 0;
        // single-shot
        cfg_mode = 8'h81; cfg_single = 1; lock_64b66b = 1;
        cfg_arm = 1; tick; cfg_arm = 0;
        tick(4); chk("ss_armed_state", int'(state), 2);
        hit_64b66b_invalid = 1; tick; chk("ss_hit1", int'(trig_out), 1);
        tick; chk("ss_hit2", int'(trig_out), 0);
        hit_64b66b_invalid = 0;
        chk("ss_done", int'(state), 4);
        cfg_arm = 1; tick; cfg_arm = 0;
        chk("ss_rearm", int'(state), 1);
        tick(4); chk("ss_requal", int'(state), 2);
        // lock loss coincident with a hit
        lock_64b66b = 0; hit_64b66b_invalid = 1; tick;
        hit_64b66b_invalid = 0; lock_64b66b = 1;
        chk("ll_trig", int'(trig_out), 0);
        chk("ll_state", int'(state), 1);
        chk("ll_flag", int'(lock_lost), 1);
        cfg_arm = 1; tick; cfg_arm = 0;
        chk("ll_clear", int'(lock_lost), 0);
        // invalid mode and arm+disarm collision
        cfg_disarm = 1; tick; cfg_disarm = 0;
        cfg_mode = 8'h42; cfg_arm = 1; tick; cfg_arm = 0;
        chk("inv_state", int'(state), 0);
        chk("inv_err", int'(mode_err), 1);
        cfg_mode = 8'h80; cfg_arm = 1; cfg_disarm = 1; tick; cfg_disarm = 0;
        chk("coll_state", int'(state), 0);
        chk("coll_err", int'(mode_err), 1);
        tick; cfg_arm = 0;
        chk("arm_clears_err", int'(mode_err), 0);
        chk("arm_state", int'(state), 1);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdr_trigger_arm_controller.md
# cdr_trigger_arm_controller

Sequences the CDR trigger datapath: selects the trigger source by mode (8B/10B pattern match, 8B/10B disparity error, 64B/66B pattern match, 64B/66B invalid symbol) and gates it on qualified symbol lock. It manages arm, single-shot and auto-rearm with holdoff, and counts triggers. It sits in the rx_clk domain between the 8B/10B and 64B/66B decode/match logic and the trigger output. All cfg_* inputs are already synchronized into rx_clk.

## Interface
- LOCK_QUAL_CYCLES, 256: consecutive locked cycles required before arming (≥1).
- HOLDOFF_WIDTH, 16: width of holdoff counter.
- COUNT_WIDTH, 32: width of trigger counter.

- rx_clk  in  1  recovered SERDES clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  8  trigger mode: 'h00 8B/10B match, 'h01 8B/10B disparity error, 'h80 64B/66B match, 'h81 64B/66B invalid; others invalid.
- cfg_arm  in  1  single-cycle arm request.
- cfg_disarm  in  1  single-cycle disarm request.
- cfg_single  in  1  1 = single-shot, 0 = auto-rearm after holdoff.
- cfg_holdoff  in  HOLDOFF_WIDTH  holdoff length in cycles.
- cfg_count_clear  in  1  single-cycle clear of trig_count.
- lock_8b10b, lock_64b66b  in  1 each  symbol lock status.
- hit_8b10b_match, hit_8b10b_disperr, hit_64b66b_match, hit_64b66b_invalid  in  1 each  per-cycle event strobes.
- trig_out  out  1  registered one-cycle trigger pulse.
- state  out  3  current FSM state.
- armed  out  1  high when state is ARMED.
- lock_lost  out  1  sticky flag: lock dropped while QUALIFY-passed (ARMED/HOLDOFF).
- mode_err  out  1  sticky flag: arm attempted with invalid mode.
- trig_count  out  COUNT_WIDTH  saturating trigger count.

## Operation
- States: IDLE=0, QUALIFY=1, ARMED=2, HOLDOFF=3, DONE=4. Reset: state IDLE, all outputs 0, all counters 0.
- Mode decode at arm: sel_lock = lock_64b66b if cfg_mode[7] else lock_8b10b. sel_hit comes from the table above. cfg_mode, cfg_single and cfg_holdoff are latched on an accepted arm. Later changes are ignored until the next arm.
- Priority per cycle: cfg_disarm, then cfg_arm, then lock/hit logic.
- cfg_disarm in any state: go to IDLE. There is no trigger that cycle. Flags are kept.
- cfg_arm with a valid mode, in any state: go to QUALIFY. This clears qual counter, lock_lost and mode_err.
- cfg_arm with an invalid mode: state is unchanged and mode_err is set.
- QUALIFY: if sel_lock = 0, qual counter goes to 0. Otherwise qual counter increments. Go to ARMED on the cycle in which the LOCK_QUAL_CYCLES-th consecutive locked cycle is sampled. Hits are ignored.
- ARMED, sel_lock = 0: go to QUALIFY, set lock_lost. No trigger, even if sel_hit = 1.
- ARMED, sel_lock = 1 and sel_hit = 1: trigger.
  - single: go to DONE.
  - else if holdoff = 0: stay in ARMED.
  - else: go to HOLDOFF and load holdoff counter = holdoff.
- HOLDOFF: decrement each cycle and go to ARMED when the counter reaches 1. Hits are ignored. sel_lock = 0 sends the FSM to QUALIFY and sets lock_lost.
- DONE: hold until cfg_arm or cfg_disarm.
- Trigger: trig_out = 1 for exactly one cycle. trig_count increments and saturates at all-ones.
- cfg_count_clear sets trig_count to 0. If a trigger happens in the same cycle, the result is 1.

## Timing
- A hit sampled in ARMED at edge T gives trig_out high during cycle T+1 (1-cycle latency). trig_count updates at the same edge as trig_out.
- Holdoff H>0: trigger at T, states T+1..T+H are HOLDOFF, ARMED resumes at T+H+1. A hit at T+H+1 fires.
- H=0 auto-rearm: back-to-back hits give back-to-back trig_out pulses.
- Qualification: lock high from cycle 0 with arm accepted at cycle 0 gives armed = 1 at cycle LOCK_QUAL_CYCLES+1.
  - A single-cycle lock dropout restarts the count from zero.
- Arm and disarm in the same cycle: disarm wins, state is IDLE, and flags are not cleared.
- Async rst mid-trigger: trig_out deasserts immediately and trig_count goes to 0.

## Test plan
- Reset → state=0, trig_out=0, trig_count=0, armed=0, flags 0. Hits in IDLE produce no trigger.
- Qualification: mode 'h00, LOCK_QUAL_CYCLES=4, lock_8b10b high, arm at cycle 0 → armed=1 at cycle 5. Repeat with lock low at cycle 2 → armed=1 at cycle 7.
- Auto-rearm: mode 'h80, holdoff=3, hits on 6 consecutive cycles starting when armed → trig_out pulses only for hit 1 and hit 5, trig_count=2.
- Single-shot: mode 'h81, single=1, two hits → one trig_out, state=4. cfg_arm → state=1, then ARMED after qualification.
- Lock loss: while ARMED, lock_64b66b drops in the same cycle as a hit → no trig_out, state=1, lock_lost=1. cfg_arm clears lock_lost.
- Invalid mode 'h42 plus cfg_arm → state stays 0, mode_err=1. Saturation: COUNT_WIDTH=2, 5 triggers → trig_count=3. count_clear with a simultaneous trigger → trig_count=1.
